// File: rtl/mem_defs_pkg.sv
// Shared definitions for the MEM stage: op codes, FSM states, op helpers.
// Optional MEM_ALIGN_CHECK_EN enables misaligned-access trapping in mem_access.
package mem_defs_pkg;

  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LBU  = 4'd2;
  localparam logic [3:0] MEM_OP_LH   = 4'd3;
  localparam logic [3:0] MEM_OP_LHU  = 4'd4;
  localparam logic [3:0] MEM_OP_LW   = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;

  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load lane select and sign/zero extension of returned read data.
// Purely combinational; offsets below the access size are ignored.
module mem_load_align
  import mem_defs_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = rdata_i[8*off_i +: 8];
    h      = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = rdata_i;
    case (op_i)
      MEM_OP_LB:  data_o = {{24{b[7]}}, b};
      MEM_OP_LBU: data_o = {24'd0, b};
      MEM_OP_LH:  data_o = {{16{h[15]}}, h};
      MEM_OP_LHU: data_o = {16'd0, h};
      default:    data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: load/store over a req/ready bus with stall and timeout.
// Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_access
  import mem_defs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_write_reg_en_i,
  input  logic [4:0]  ex_write_reg_addr_i,
  input  logic [31:0] ex_alu_result_i,
  input  logic [3:0]  ex_mem_op_i,
  input  logic [31:0] ex_store_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i,
  output logic        stall_o,
  output logic        mem_write_reg_en_o,
  output logic [4:0]  mem_write_reg_addr_o,
  output logic [31:0] mem_write_reg_data_o,
  output logic        bus_err_o,
  output logic        align_err_o
);

  mem_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]  off;
  logic        ld, st, align_bad, access;
  logic        wait_st, expire, req, done;
  logic [3:0]  be;
  logic [31:0] wdata, ld_data;

  assign off = ex_alu_result_i[1:0];
  assign ld  = is_load(ex_mem_op_i);
  assign st  = is_store(ex_mem_op_i);

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    align_bad = 1'b0;
    case (ex_mem_op_i)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: align_bad = off[0];
      MEM_OP_LW, MEM_OP_SW:             align_bad = |off;
      default:                          align_bad = 1'b0;
    endcase
  end
  assign align_err_o = rst & align_bad;
`else
  assign align_bad   = 1'b0;
  assign align_err_o = 1'b0;
`endif

  assign access  = (ld | st) & ~align_bad;
  assign wait_st = (state_q == ST_WAIT);
  assign expire  = wait_st & ~dmem_ready_i &
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign req     = rst & (access | wait_st);
  assign done    = req & dmem_ready_i;

  always_comb begin
    be    = 4'b1111;
    wdata = ex_store_data_i;
    case (ex_mem_op_i)
      MEM_OP_SB: begin
        be    = 4'b0001 << off;
        wdata = {4{ex_store_data_i[7:0]}};
      end
      MEM_OP_SH: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{ex_store_data_i[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = ex_store_data_i;
      end
    endcase
  end

  mem_load_align u_align (
    .op_i    (ex_mem_op_i),
    .off_i   (off),
    .rdata_i (dmem_rdata_i),
    .data_o  (ld_data)
  );

  assign dmem_req_o   = req;
  assign dmem_we_o    = req & st;
  assign dmem_addr_o  = req ? {ex_alu_result_i[31:2], 2'b00} : 32'd0;
  assign dmem_be_o    = req ? be : 4'd0;
  assign dmem_wdata_o = req ? wdata : 32'd0;
  assign stall_o      = req & ~dmem_ready_i & ~expire;
  assign bus_err_o    = rst & expire;

  // Loads write back only on completion; aborts and stalls insert bubbles.
  assign mem_write_reg_en_o = rst & ex_write_reg_en_i & ~st &
                              ~align_bad & (~ld | done);
  assign mem_write_reg_addr_o = rst ? ex_write_reg_addr_i : 5'd0;
  assign mem_write_reg_data_o = !rst ? 32'd0 :
                                ld ? ld_data : ex_alu_result_i;

  // The idle cycle that issues the request counts as the first wait cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access && !dmem_ready_i) begin
            state_q <= ST_WAIT;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        ST_WAIT: begin
          if (dmem_ready_i || expire) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access with a randomized memory-latency model.
// Build with MEM_ALIGN_CHECK_EN to exercise the alignment trap variant.
module tb_mem_access;
  import mem_defs_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_en = 1'b0;
  logic [4:0]  ex_ra = '0;
  logic [31:0] ex_alu = '0;
  logic [3:0]  ex_op = '0;
  logic [31:0] ex_sd = '0;
  logic        req, we, stall, en, berr, aerr;
  logic [31:0] maddr, wdata, wb_data;
  logic [3:0]  be;
  logic [4:0]  wb_ra;
  logic [31:0] rdata = '0;
  logic        ready = 1'b0;

  int checks = 0;
  int errors = 0;
  bit active = 1'b0;
  int stall_n = 0;

  typedef struct {
    logic        en;
    logic [4:0]  ra;
    logic [31:0] data;
    bit          chk_data;
    logic        berr;
    logic        aerr;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wdata;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  mem_access #(.TIMEOUT_CYCLES(T)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ex_write_reg_en_i    (ex_en),
    .ex_write_reg_addr_i  (ex_ra),
    .ex_alu_result_i      (ex_alu),
    .ex_mem_op_i          (ex_op),
    .ex_store_data_i      (ex_sd),
    .dmem_req_o           (req),
    .dmem_we_o            (we),
    .dmem_addr_o          (maddr),
    .dmem_be_o            (be),
    .dmem_wdata_o         (wdata),
    .dmem_rdata_i         (rdata),
    .dmem_ready_i         (ready),
    .stall_o              (stall),
    .mem_write_reg_en_o   (en),
    .mem_write_reg_addr_o (wb_ra),
    .mem_write_reg_data_o (wb_data),
    .bus_err_o            (berr),
    .align_err_o          (aerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [31:0] a, sd,
                                 input logic we_en, input logic [4:0] ra,
                                 input logic [31:0] rd, input int n);
    exp_t e;
    int   o, bv, hv;
    bit   ldop, stop, mis, tmo;
    ldop = (op >= 1) && (op <= 5);
    stop = (op >= 6) && (op <= 8);
    o    = int'(a[1:0]);
    mis  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if (op == 3 || op == 4 || op == 7) mis = (o % 2) != 0;
    if (op == 5 || op == 8) mis = o != 0;
`endif
    tmo = (ldop || stop) && !mis && n >= T;
    bv  = int'((rd >> (8 * o)) & 32'hFF);
    hv  = int'((rd >> (16 * (o / 2))) & 32'hFFFF);
    e.ra        = ra;
    e.aerr      = mis;
    e.berr      = tmo;
    e.req       = (ldop || stop) && !mis;
    e.we        = stop && !mis;
    e.addr      = e.req ? (a / 4) * 4 : 32'd0;
    e.stalls    = tmo ? T - 1 : (e.req ? n : 0);
    e.en        = (!ldop && !stop) ? we_en :
                  (ldop && !mis && !tmo) ? we_en : 1'b0;
    e.chk_data  = e.en || (!ldop && !stop);
    e.data      = a;
    case (op)
      1: e.data = (bv >= 128) ? bv - 256 : bv;
      2: e.data = bv;
      3: e.data = (hv >= 32768) ? hv - 65536 : hv;
      4: e.data = hv;
      5: e.data = rd;
      default: e.data = a;
    endcase
    e.chk_wdata = e.we;
    e.be        = 4'hF;
    e.wdata     = sd;
    if (op == 6) begin
      e.be    = 4'(1 << o);
      e.wdata = (sd & 32'hFF) * 32'h01010101;
    end else if (op == 7) begin
      e.be    = (o >= 2) ? 4'hC : 4'h3;
      e.wdata = (sd & 32'hFFFF) * 32'h00010001;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      stall_n = 0;
    end else if (active) begin
      if (stall) begin
        stall_n++;
        chk("stall_en", 32'(en), 32'd0);
        chk("stall_req", 32'(req), 32'd1);
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: output with no expected entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("stalls", 32'(stall_n), 32'(e.stalls));
        chk("wb_en", 32'(en), 32'(e.en));
        chk("wb_ra", 32'(wb_ra), 32'(e.ra));
        if (e.chk_data) chk("wb_data", wb_data, e.data);
        chk("bus_err", 32'(berr), 32'(e.berr));
        chk("align_err", 32'(aerr), 32'(e.aerr));
        chk("req", 32'(req), 32'(e.req));
        chk("we", 32'(we), 32'(e.we));
        chk("maddr", maddr, e.addr);
        if (e.chk_wdata) begin
          chk("be", 32'(be), 32'(e.be));
          chk("wdata", wdata, e.wdata);
        end
        stall_n = 0;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, sd,
                       input logic we_en, input logic [4:0] ra,
                       input logic [31:0] rd, input int n);
    int k;
    sb.push_back(model(op, a, sd, we_en, ra, rd, n));
    active = 1'b1;
    ex_op  = op;
    ex_alu = a;
    ex_sd  = sd;
    ex_en  = we_en;
    ex_ra  = ra;
    k      = 0;
    forever begin
      ready = (k == n);
      rdata = (k == n) ? rd : $urandom;
      @(negedge clk);
      if (!stall) break;
      k++;
      if (k > T + 2) begin
        checks++;
        errors++;
        $display("FAIL stall_bound: stall %0d cycles limit %0d", k, T + 2);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    active = 1'b0;
    ready  = 1'b0;
  endtask

  initial begin
    ex_op  = MEM_OP_LW;
    ex_en  = 1'b1;
    ex_alu = 32'h100;
    ex_ra  = 5'd3;
    ready  = 1'b0;
    #2;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    chk("rst_berr", 32'(berr), 32'd0);
    ex_op = MEM_OP_NONE;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    issue(MEM_OP_LW, 32'h100, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 0);
    issue(MEM_OP_LB, 32'h103, 32'h0, 1'b1, 5'd6, 32'h80FFFFFF, 3);
    issue(MEM_OP_LBU, 32'h103, 32'h0, 1'b1, 5'd6, 32'h80FFFFFF, 3);
    issue(MEM_OP_SH, 32'h202, 32'h1234ABCD, 1'b1, 5'd7, 32'h0, 0);
    issue(MEM_OP_LW, 32'h40, 32'h0, 1'b1, 5'd8, 32'h55AA55AA, 99);
    issue(MEM_OP_LW, 32'h44, 32'h0, 1'b1, 5'd8, 32'h01234567, T - 1);
    issue(MEM_OP_LW, 32'h101, 32'h0, 1'b1, 5'd9, 32'h11223344, 0);
    issue(MEM_OP_NONE, 32'hCAFEF00D, 32'h0, 1'b1, 5'd10, 32'h0, 0);

    ex_op  = MEM_OP_LW;
    ex_alu = 32'h80;
    ex_en  = 1'b1;
    ready  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("wait_rst_req", 32'(req), 32'd0);
    chk("wait_rst_stall", 32'(stall), 32'd0);
    chk("wait_rst_en", 32'(en), 32'd0);
    ex_op = MEM_OP_NONE;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(MEM_OP_LH, 32'h82, 32'h0, 1'b1, 5'd11, 32'h8001_7FFF, T - 1);

    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), $urandom, $urandom,
            1'($urandom), 5'($urandom), $urandom,
            int'($urandom_range(0, T + 1)));
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access (MEM) stage of the 5-stage pipeline. Takes the EX/MEM payload (register write request, ALU result, memory op, address and store data) and performs loads and stores over a req/ready data-memory handshake. It stalls the pipeline while memory is busy and produces the write-back triple consumed by the MEM/WB pipeline register. Load results are byte/half extracted and sign- or zero-extended before hand-off.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles without `dmem_ready_i` before the access is aborted. Legal range 2..255.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ex_write_reg_en_i` in 1: instruction writes the register file.
- `ex_write_reg_addr_i` in 5: destination register.
- `ex_alu_result_i` in 32: ALU result; also used as the memory address.
- `ex_mem_op_i` in 4: memory operation code.
- `ex_store_data_i` in 32: store source (rt).
- `dmem_req_o` out 1: access request.
- `dmem_we_o` out 1: 1 = store.
- `dmem_addr_o` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_be_o` out 4: byte enables, little-endian.
- `dmem_wdata_o` out 32: lane-replicated store data.
- `dmem_rdata_i` in 32: read data, valid when ready.
- `dmem_ready_i` in 1: access completes this cycle.
- `stall_o` out 1: freeze IF..EX/MEM.
- `mem_write_reg_en_o` out 1: to MEM/WB.
- `mem_write_reg_addr_o` out 5: to MEM/WB.
- `mem_write_reg_data_o` out 32: to MEM/WB.
- `bus_err_o` out 1: timeout abort, one-cycle pulse.
- `align_err_o` out 1: misaligned access, one-cycle pulse (see Configuration).

## Operation
- Op codes: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW. Codes 9..15 are treated as NONE.
- NONE: no request, no stall. Outputs pass through: en, addr, and data = `ex_alu_result_i`.
- FSM states:
  - IDLE: on a memory op, assert `dmem_req_o` combinationally. If `dmem_ready_i` is high in the same cycle, the access completes with no stall. Otherwise `stall_o`=1 and the FSM goes to WAIT.
  - WAIT: hold `dmem_req_o` and all `dmem_*` outputs, `stall_o`=1. On ready: complete, drop stall, return to IDLE. On timeout: abort.
- Upstream holds the `ex_*` inputs stable while `stall_o`=1 and advances on every cycle with `stall_o`=0.
- Load extraction uses `addr[1:0]`:
  - LB/LBU select byte lane; LB sign-extends, LBU zero-extends.
  - LH/LHU select lane `addr[1]`, with sign or zero extension.
  - LW takes the full word.
- Stores:
  - SB: `be=1<<addr[1:0]`, wdata = byte replicated ×4.
  - SH: be = 4'b0011 or 4'b1100, wdata = half replicated ×2.
  - SW: be = 4'b1111.
  - Stores force `mem_write_reg_en_o`=0.
- Register write-back fields are valid only in the completing cycle. In stall cycles `mem_write_reg_en_o`=0 (a bubble enters MEM/WB).
- Timeout counter:
  - Cleared in IDLE; increments each WAIT cycle without ready.
  - If the count equals `TIMEOUT_CYCLES-1` with no ready: `bus_err_o`=1, `stall_o`=0, `mem_write_reg_en_o`=0, FSM returns to IDLE.
  - If ready and expiry fall in the same cycle, ready wins and there is no error.

## Timing
- Reset (`rst` low): FSM goes to IDLE and the counter clears immediately. All outputs are forced to 0 while reset is asserted, including `dmem_req_o`, `stall_o`, the `mem_*` outputs and both error flags.
- Reset during WAIT abandons the access and drops the request asynchronously.
- Zero-wait access: 0 stall cycles; result reaches MEM/WB at the next edge.
- N-wait access: `stall_o` is high for N cycles, and low in the cycle `dmem_ready_i` rises.
- Timeout: `stall_o` is high for exactly `TIMEOUT_CYCLES-1` cycles, then one abort cycle with `bus_err_o`=1.
- Back-to-back memory ops: the next request may issue in the cycle after completion.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Applies to LH/LHU/SH with `addr[0]`=1, and to LW/SW with `addr[1:0]`≠0.
  - No request is issued and there is no stall.
  - `align_err_o`=1 for that cycle and `mem_write_reg_en_o`=0.
- Undefined:
  - Offset bits below access size are ignored (halves use `addr[1]`, words use lane 0).
  - `align_err_o` is tied 0.

## Structure
- Shared package `mem_defs_pkg`:
  - Op-code constants `MEM_OP_*` and the FSM state encoding.
  - Helper functions `is_load` / `is_store`.
- Sub-module `mem_load_align`: combinational lane select and extension of `dmem_rdata_i` by op and `addr[1:0]`. The FSM, counter and store-lane logic stay in `mem_access`.

## Test plan
- LW at 0x100, ready same cycle, rdata 0xDEADBEEF → no stall; en=1, data=0xDEADBEEF.
- LB at 0x103, ready after 3 cycles, rdata 0x80FFFFFF → stall 3 cycles; data=0xFFFFFF80. LBU of same → 0x00000080.
- SH at 0x202, store data 0x1234ABCD → be=4'b1100, wdata=0xABCDABCD, we=1, en=0.
- Ready never asserted, TIMEOUT_CYCLES=4 → stall 3 cycles, then `bus_err_o` pulse and en=0. With ready on the expiry cycle → normal completion, no error.
- `rst` pulled low on the second WAIT cycle → req/stall drop immediately. After release, IDLE with the counter at 0.
- With `MEM_ALIGN_CHECK_EN`, LW at 0x101 → `align_err_o`=1, no req, en=0. Without it → word at 0x100 is read.
